compound_accumulator: RTL and testbench
=======================================

Name: compound_accumulator

Overview:
- Downstream consumer of the CompoundType blocking output stage (b_out/b_out_sync/b_out_notify).
- Accepts CompoundType transactions over a blocking input port and accumulates the x fields under control of mode and y.
- On a read request, returns the accumulated value and the accepted-transaction count over a blocking output port.
- Two-section FSM; one transaction at a time; no buffering beyond a single result register.

Parameters:
- CNT_W, 16, width of the accepted-write counter (saturating).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- b_in  input  CompoundType  transaction from upstream {mode: read/write, x: signed 32, y: bool}
- b_in_sync  input  1  upstream has valid data on b_in
- b_in_notify  output  1  this block is ready to read b_in
- res_out  output  32  accumulated value (signed)
- res_cnt  output  CNT_W  number of write transactions since the last read
- res_out_sync  input  1  downstream ready to take result
- res_out_notify  output  1  result valid, waiting for downstream
- ovf  output  1  sticky signed-overflow flag for the current accumulation epoch

Behaviour:
- Handshake: a transfer occurs at a posedge where both notify (own) and sync (peer) are high. Data is sampled at that edge. No combinational path from sync to notify; all outputs are registered.
- Reset (async): section=SEC_READ, acc=0, cnt=0, ovf=0, res_out=0, res_cnt=0, b_in_notify=1, res_out_notify=0.
- SEC_READ: b_in_notify=1, res_out_notify=0. On a b_in transfer:
  - mode=write, y=1: acc <= acc + x (32-bit two's-complement wrap). If signed overflow occurs, ovf <= 1 (sticky). cnt <= cnt+1, saturating at all-ones. Stay in SEC_READ; next transfer can occur on the following cycle (throughput 1/cycle).
  - mode=write, y=0: acc <= x (load). ovf <= 0. cnt <= cnt+1, saturating. Stay in SEC_READ.
  - mode=read (x and y ignored): res_out <= acc; res_cnt <= cnt; b_in_notify <= 0; res_out_notify <= 1; go to SEC_WRITE. acc, ovf and cnt are unchanged at this edge.
- SEC_WRITE: b_in_notify=0 (upstream stalls). res_out_notify stays 1 and res_out/res_cnt stay stable until res_out_sync=1 at a posedge. At that edge: res_out_notify <= 0; b_in_notify <= 1; cnt <= 0; ovf <= 0; acc retained; go to SEC_READ.
- Latency: the read request transfers at edge N; the result is valid with res_out_notify=1 after edge N; the earliest completion is edge N+1; the next b_in transfer is no earlier than edge N+2.
- Boundaries:
  - b_in_sync held high in SEC_WRITE: ignored, no capture.
  - res_out_sync high in SEC_READ: ignored.
  - cnt at max plus a write: stays at max.
  - acc = 0x7FFFFFFF, add 1: acc = 0x80000000, ovf=1.
  - Reset asserted mid-SEC_WRITE: result is dropped and all registers return to reset values immediately.
- The FSM has only two legal states. An illegal encoding goes to SEC_READ with reset values.

Decomposition:
- Reuse CompoundType and the mode enum (read/write) from testbasic17_types.
- New package compound_accumulator_types: enum Sections_acc {SEC_READ, SEC_WRITE}.
- One sub-module, acc_add32: combinational signed 32-bit add with overflow output (ovf = operand signs equal and sum sign differs). The FSM, counter and registers stay in the top module.

Test Plan:
- Reset, then writes {write, x=5, y=0}, {write, 3, y=1}, {write, -10, y=1}, then {read} with res_out_sync=1 -> res_out=-2 (0xFFFFFFFE), res_cnt=3, ovf=0; res_out_notify high for exactly 1 cycle.
- Load 0x7FFFFFFF (y=0), add 1 (y=1), read -> res_out=0x80000000, ovf=1. After read completes, ovf=0 and cnt=0.
- Read issued, res_out_sync held low 5 cycles while b_in_sync=1 with {write, 7, 1} -> b_in_notify=0, res_out stable, acc unchanged. Raise sync -> completes; the pending write is accepted the next cycle.
- CNT_W=2: 5 writes then read -> res_cnt=3 (saturated).
- Async rst pulse mid-SEC_WRITE (between edges) -> res_out_notify=0, b_in_notify=1, res_out=0 immediately. A subsequent read returns res_out=0, res_cnt=0.
- Back-to-back writes every cycle with b_in_sync=1 for 8 cycles, x=1, y=1 after a load of 0 -> read gives res_out=8, res_cnt=9.

Source files
------------

// File: rtl/compound_accumulator_pkg.sv
// Shared types for the compound accumulator slice.
//   testbasic17_types          : CompoundType transaction and its read/write mode enum
//   compound_accumulator_types : section encoding of the accumulator FSM
// The FSM encoding is two bits wide on purpose, so unused codes exist and can be
// steered back to SEC_READ.

package testbasic17_types;

   typedef enum logic {
      MODE_READ  = 1'b0,
      MODE_WRITE = 1'b1
   } mode_e;

   typedef struct packed {
      mode_e              mode;
      logic signed [31:0] x;
      logic               y;
   } CompoundType;

endpackage

package compound_accumulator_types;

   typedef enum logic [1:0] {
      SEC_READ  = 2'b00,
      SEC_WRITE = 2'b01
   } Sections_acc;

endpackage

// File: rtl/acc_add32.sv
// Combinational signed 32-bit adder with overflow detect.
// Ports:
//   a, b : signed operands
//   sum  : a + b, two's-complement wrap
//   ovf  : signed overflow (operand signs equal, result sign differs)

module acc_add32 (
   input  logic signed [31:0] a,
   input  logic signed [31:0] b,
   output logic signed [31:0] sum,
   output logic               ovf
);

   always_comb begin
      sum = a + b;
      ovf = (a[31] == b[31]) && (sum[31] != a[31]);
   end

endmodule

// File: rtl/compound_accumulator.sv
// Accumulator consuming CompoundType transactions over a blocking input port.
// Writes either load (y=0) or add (y=1) x into the accumulator; a read hands the
// accumulated value and the write count out over a blocking result port, then
// starts a new epoch (count and overflow cleared, accumulator kept).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   b_in            : upstream transaction {mode, x, y}
//   b_in_sync       : upstream data valid
//   b_in_notify     : ready to accept b_in (registered)
//   res_out         : captured accumulator value
//   res_cnt         : captured write count (saturating, CNT_W bits)
//   res_out_sync    : downstream ready for result
//   res_out_notify  : result valid (registered)
//   ovf             : sticky signed overflow for the current epoch

module compound_accumulator
   import testbasic17_types::*;
   import compound_accumulator_types::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  CompoundType         b_in,
   input  logic                b_in_sync,
   output logic                b_in_notify,
   output logic signed [31:0]  res_out,
   output logic [CNT_W-1:0]    res_cnt,
   input  logic                res_out_sync,
   output logic                res_out_notify,
   output logic                ovf
);

   Sections_acc        section_q, section_d;
   logic signed [31:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic signed [31:0] res_out_q, res_out_d;
   logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
   logic               b_in_notify_q, b_in_notify_d;
   logic               res_out_notify_q, res_out_notify_d;

   logic signed [31:0] add_sum;
   logic               add_ovf;

   acc_add32 u_add (
      .a   (acc_q),
      .b   (b_in.x),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   always_comb begin
      section_d        = section_q;
      acc_d            = acc_q;
      cnt_d            = cnt_q;
      ovf_d            = ovf_q;
      res_out_d        = res_out_q;
      res_cnt_d        = res_cnt_q;
      b_in_notify_d    = b_in_notify_q;
      res_out_notify_d = res_out_notify_q;

      case (section_q)
         SEC_READ: begin
            b_in_notify_d    = 1'b1;
            res_out_notify_d = 1'b0;
            if (b_in_sync) begin
               if (b_in.mode == MODE_WRITE) begin
                  cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                  if (b_in.y) begin
                     acc_d = add_sum;
                     if (add_ovf) ovf_d = 1'b1;
                  end else begin
                     acc_d = b_in.x;
                     ovf_d = 1'b0;
                  end
               end else begin
                  res_out_d        = acc_q;
                  res_cnt_d        = cnt_q;
                  b_in_notify_d    = 1'b0;
                  res_out_notify_d = 1'b1;
                  section_d        = SEC_WRITE;
               end
            end
         end
         SEC_WRITE: begin
            if (res_out_sync) begin
               res_out_notify_d = 1'b0;
               b_in_notify_d    = 1'b1;
               cnt_d            = '0;
               ovf_d            = 1'b0;
               section_d        = SEC_READ;
            end
         end
         default: begin
            // Unused encoding: recover to the reset state.
            section_d        = SEC_READ;
            acc_d            = '0;
            cnt_d            = '0;
            ovf_d            = 1'b0;
            res_out_d        = '0;
            res_cnt_d        = '0;
            b_in_notify_d    = 1'b1;
            res_out_notify_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         section_q        <= SEC_READ;
         acc_q            <= '0;
         cnt_q            <= '0;
         ovf_q            <= 1'b0;
         res_out_q        <= '0;
         res_cnt_q        <= '0;
         b_in_notify_q    <= 1'b1;
         res_out_notify_q <= 1'b0;
      end else begin
         section_q        <= section_d;
         acc_q            <= acc_d;
         cnt_q            <= cnt_d;
         ovf_q            <= ovf_d;
         res_out_q        <= res_out_d;
         res_cnt_q        <= res_cnt_d;
         b_in_notify_q    <= b_in_notify_d;
         res_out_notify_q <= res_out_notify_d;
      end
   end

   assign b_in_notify    = b_in_notify_q;
   assign res_out_notify = res_out_notify_q;
   assign res_out        = res_out_q;
   assign res_cnt        = res_cnt_q;
   assign ovf            = ovf_q;

endmodule

// File: tb/tb_compound_accumulator.sv
// Scoreboard bench: stimulus updates a transaction-level model and queues the
// expected result of every read; a monitor pops and compares whenever a result
// becomes valid. A second instance with CNT_W=2 sees the same stimulus so
// counter saturation is observed alongside the normal-width instance.

module tb_compound_accumulator;
   import testbasic17_types::*;

   localparam longint MaxV = 64'sh7FFF_FFFF;
   localparam longint MinV = -64'sh8000_0000;

   typedef struct {
      longint res;
      int     cnt;
      int     cnt2;
      bit     ovf;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   CompoundType        b_in;
   logic               b_in_sync;
   logic               res_out_sync;
   logic               b_in_notify, s_b_in_notify;
   logic signed [31:0] res_out, s_res_out;
   logic [15:0]        res_cnt;
   logic [1:0]         s_res_cnt;
   logic               res_out_notify, s_res_out_notify;
   logic               ovf, s_ovf;

   int compared   = 0;
   int mismatched = 0;

   exp_t   exp_q[$];
   exp_t   mon_e;
   bit     mon_seen;

   // Model state: accumulator value, writes this epoch, overflow, result pending.
   longint m_acc;
   int     m_cnt;
   bit     m_ovf;
   bit     m_wr;

   always #5 clk = ~clk;

   compound_accumulator #(.CNT_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .b_in           (b_in),
      .b_in_sync      (b_in_sync),
      .b_in_notify    (b_in_notify),
      .res_out        (res_out),
      .res_cnt        (res_cnt),
      .res_out_sync   (res_out_sync),
      .res_out_notify (res_out_notify),
      .ovf            (ovf)
   );

   compound_accumulator #(.CNT_W(2)) dut_small (
      .clk            (clk),
      .rst            (rst),
      .b_in           (b_in),
      .b_in_sync      (b_in_sync),
      .b_in_notify    (s_b_in_notify),
      .res_out        (s_res_out),
      .res_cnt        (s_res_cnt),
      .res_out_sync   (res_out_sync),
      .res_out_notify (s_res_out_notify),
      .ovf            (s_ovf)
   );

   task automatic check(input string name, input longint act, input longint exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int max_v);
      return (v > max_v) ? max_v : v;
   endfunction

   task automatic model_reset();
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 0;
      m_wr  = 0;
   endtask

   task automatic model_step(input bit isync, input bit wr, input int x, input bit y,
                             input bit osync);
      longint s;
      exp_t   e;
      if (!m_wr) begin
         if (isync) begin
            if (wr) begin
               m_cnt++;
               if (y) begin
                  s = m_acc + longint'(x);
                  if (s > MaxV || s < MinV) m_ovf = 1;
                  if (s > MaxV) s -= 64'sh1_0000_0000;
                  if (s < MinV) s += 64'sh1_0000_0000;
                  m_acc = s;
               end else begin
                  m_acc = longint'(x);
                  m_ovf = 0;
               end
            end else begin
               e.res  = m_acc;
               e.cnt  = sat(m_cnt, 65535);
               e.cnt2 = sat(m_cnt, 3);
               e.ovf  = m_ovf;
               exp_q.push_back(e);
               m_wr = 1;
            end
         end
      end else if (osync) begin
         m_wr  = 0;
         m_cnt = 0;
         m_ovf = 0;
      end
   endtask

   // One clock: drive at negedge, model the edge, check handshake outputs after it.
   task automatic cycle(input bit isync, input bit wr, input int x, input bit y,
                        input bit osync);
      @(negedge clk);
      b_in_sync    = isync;
      b_in.mode    = wr ? MODE_WRITE : MODE_READ;
      b_in.x       = x;
      b_in.y       = y;
      res_out_sync = osync;
      @(posedge clk);
      model_step(isync, wr, x, y, osync);
      #1;
      check("b_in_notify", b_in_notify, !m_wr);
      check("res_out_notify", res_out_notify, m_wr);
      check("ovf", ovf, m_ovf);
      check("small_res_out_notify", s_res_out_notify, m_wr);
   endtask

   task automatic wr_op(input int x, input bit y);
      cycle(1, 1, x, y, 0);
   endtask

   task automatic rd_op();
      cycle(1, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
   endtask

   // Monitor: compare each result once when it becomes valid, then check stability.
   initial begin
      mon_seen = 0;
      forever begin
         @(negedge clk);
         if (res_out_notify) begin
            if (!mon_seen) begin
               mon_seen = 1;
               check("result_expected", (exp_q.size() > 0) ? 1 : 0, 1);
               if (exp_q.size() > 0) begin
                  mon_e = exp_q.pop_front();
                  check("res_out", res_out, mon_e.res);
                  check("res_cnt", res_cnt, mon_e.cnt);
                  check("ovf_at_result", ovf, mon_e.ovf);
                  check("small_res_out", s_res_out, mon_e.res);
                  check("small_res_cnt", s_res_cnt, mon_e.cnt2);
               end
            end else begin
               check("res_out_stable", res_out, mon_e.res);
            end
         end else begin
            mon_seen = 0;
         end
      end
   end

   initial begin
      int x;
      rst          = 1;
      b_in_sync    = 0;
      b_in         = '0;
      res_out_sync = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_b_in_notify", b_in_notify, 1);
      check("rst_res_out_notify", res_out_notify, 0);
      check("rst_res_out", res_out, 0);
      check("rst_res_cnt", res_cnt, 0);
      check("rst_ovf", ovf, 0);
      rst = 0;

      // Load, add, add negative, read with downstream already ready.
      wr_op(5, 0);
      wr_op(3, 1);
      wr_op(-10, 1);
      rd_op();

      // Positive overflow into the sign bit.
      wr_op(32'h7FFF_FFFF, 0);
      wr_op(1, 1);
      rd_op();
      check("ovf_cleared_after_read", ovf, 0);

      // Stalled result while upstream keeps offering a write.
      cycle(1, 0, 0, 0, 0);
      repeat (5) cycle(1, 1, 7, 1, 0);
      cycle(1, 1, 7, 1, 1);
      cycle(1, 1, 7, 1, 0);
      rd_op();

      // Five writes: the narrow counter saturates at 3.
      repeat (5) wr_op(2, 1);
      rd_op();

      // Asynchronous reset between edges while a result is pending.
      wr_op(1234, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      #1;
      rst = 1;
      #1;
      check("midrst_res_out_notify", res_out_notify, 0);
      check("midrst_b_in_notify", b_in_notify, 1);
      check("midrst_res_out", res_out, 0);
      check("midrst_res_cnt", res_cnt, 0);
      rst = 0;
      model_reset();
      rd_op();

      // Back-to-back adds at full throughput.
      wr_op(0, 0);
      repeat (8) wr_op(1, 1);
      rd_op();

      // Randomised traffic, including extreme operands.
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 4))
            0:       x = 32'h7FFF_FFF0 + int'($urandom_range(0, 15));
            1:       x = 32'h8000_0000 + int'($urandom_range(0, 15));
            default: x = int'($urandom_range(0, 200)) - 100;
         endcase
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, x,
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      end
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
